// File: rtl/estufa_pkg.sv
// Shared definitions for the greenhouse sensor path: filter states and the
// sensor code constants used by both the filter and the decision stage.
package estufa_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    STABLE = 2'd1,
    SETTLE = 2'd2
  } filt_state_t;

  // Sensor codes: bit 1 = T>Tmin, bit 0 = T>Tmax
  localparam logic [1:0] SENS_COLD = 2'b00;
  localparam logic [1:0] SENS_INC  = 2'b01;
  localparam logic [1:0] SENS_OK   = 2'b10;
  localparam logic [1:0] SENS_HOT  = 2'b11;

endpackage

// File: rtl/estufa_sync2.sv
// Two-flop synchroniser for the raw threshold-sensor switches.
module estufa_sync2 #(
  parameter int W = 2
) (
  input  logic         clk_2,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Two-stage capture; only the second stage is visible to the filter
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/estufa_sensor_filter.sv
// Debounce filter for the sensor pair feeding the heater/cooler decision stage.
// A new code is adopted only after NSTABLE consecutive equal synchronised
// samples; aborted transitions and adoptions of the impossible code 01 are
// counted in saturating statistics counters.
//
// state  | meaning
// INIT   | no code adopted yet since reset; qualifying the first code
// STABLE | sens_stable valid, synchronised input agrees with it
// SETTLE | input differs from sens_stable; qualifying candidate code
module estufa_sensor_filter
  import estufa_pkg::*;
#(
  parameter int NSTABLE = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [1:0]       sens_raw,
  output logic [1:0]       sens_stable,
  output logic             sens_valid,
  output logic             change,
  output logic             inconsist,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int             CW     = $clog2(NSTABLE) + 1;
  localparam logic [CW-1:0]  C_LAST = CW'(NSTABLE - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  filt_state_t      r_state;
  logic [1:0]       r_cand;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_stable;
  logic             r_valid;
  logic             r_change;
  logic             r_inconsist;
  logic [CNT_W-1:0] r_glitch;
  logic [CNT_W-1:0] r_fault;

  logic [1:0]       w_s2;
  logic             w_glitch_evt;
  logic             w_adopt_init;
  logic             w_adopt_settle;
  logic             w_fault_evt;

  estufa_sync2 #(.W(2)) u_sync (
    .clk_2 (clk_2),
    .reset (reset),
    .d     (sens_raw),
    .q     (w_s2)
  );

  // Events shared by the FSM and the statistics counters, in SETTLE priority order
  assign w_glitch_evt   = (r_state == SETTLE) && (w_s2 == r_stable);
  assign w_adopt_settle = (r_state == SETTLE) && (w_s2 != r_stable) &&
                          (w_s2 == r_cand) && (r_cnt == C_LAST);
  assign w_adopt_init   = (r_state == INIT) && (w_s2 == r_cand) && (r_cnt == C_LAST);
  assign w_fault_evt    = (w_adopt_init || w_adopt_settle) && (r_cand == SENS_INC);

  // Filter FSM with candidate tracking, qualification counter and registered outputs
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state     <= INIT;
      r_cand      <= SENS_COLD;
      r_cnt       <= '0;
      r_stable    <= SENS_COLD;
      r_valid     <= 1'b0;
      r_change    <= 1'b0;
      r_inconsist <= 1'b0;
    end else begin
      r_change    <= 1'b0;
      r_inconsist <= r_valid && (r_stable == SENS_INC);
      unique case (r_state)
        INIT: begin
          if (w_s2 == r_cand) begin
            if (r_cnt == C_LAST) begin
              // First adoption is silent: no prior code to change from
              r_stable <= r_cand;
              r_valid  <= 1'b1;
              r_cnt    <= '0;
              r_state  <= STABLE;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
            r_cand <= w_s2;
            r_cnt  <= C_ONE;
          end
        end
        STABLE: begin
          if (w_s2 != r_stable) begin
            r_cand  <= w_s2;
            r_cnt   <= C_ONE;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_s2 == r_stable) begin
            r_cnt   <= '0;
            r_state <= STABLE;
          end else if (w_s2 != r_cand) begin
            r_cand <= w_s2;
            r_cnt  <= C_ONE;
          end else if (r_cnt == C_LAST) begin
            r_stable <= r_cand;
            r_change <= 1'b1;
            r_cnt    <= '0;
            r_state  <= STABLE;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= INIT;
        end
      endcase
    end
  end

  // Saturating glitch/fault statistics
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_glitch <= '0;
      r_fault  <= '0;
    end else begin
      if (w_glitch_evt && (r_glitch != {CNT_W{1'b1}})) begin
        r_glitch <= r_glitch + 1'b1;
      end
      if (w_fault_evt && (r_fault != {CNT_W{1'b1}})) begin
        r_fault <= r_fault + 1'b1;
      end
    end
  end

  assign sens_stable = r_stable;
  assign sens_valid  = r_valid;
  assign change      = r_change;
  assign inconsist   = r_inconsist;
  assign glitch_cnt  = r_glitch;
  assign fault_cnt   = r_fault;

endmodule

// File: tb/tb_estufa_sensor_filter.sv
// Directed bench for the sensor debounce filter (NSTABLE=4, CNT_W=4).
module tb_estufa_sensor_filter;

  logic       clk_2;
  logic       reset;
  logic [1:0] sens_raw;
  logic [1:0] sens_stable;
  logic       sens_valid;
  logic       change;
  logic       inconsist;
  logic [3:0] glitch_cnt;
  logic [3:0] fault_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int n_change = 0;
  int base_chg;

  estufa_sensor_filter #(.NSTABLE(4), .CNT_W(4)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .sens_raw    (sens_raw),
    .sens_stable (sens_stable),
    .sens_valid  (sens_valid),
    .change      (change),
    .inconsist   (inconsist),
    .glitch_cnt  (glitch_cnt),
    .fault_cnt   (fault_cnt)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Count change pulses, sampled away from the active edge
  always @(negedge clk_2) if (change === 1'b1) n_change++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  initial begin
    // Power-up: reset held 3 cycles with raw=11
    reset    = 1'b1;
    sens_raw = 2'b11;
    tick(3);
    chk("rst_stable",   {6'd0, sens_stable}, 8'h00);
    chk("rst_valid",    {7'd0, sens_valid},  8'h00);
    chk("rst_change",   {7'd0, change},      8'h00);
    chk("rst_inconsist",{7'd0, inconsist},   8'h00);
    chk("rst_glitch",   {4'd0, glitch_cnt},  8'h00);
    chk("rst_fault",    {4'd0, fault_cnt},   8'h00);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("pu_valid_e%0d", i), {7'd0, sens_valid}, 8'h00);
    end
    tick(1);
    chk("pu_valid_e6",  {7'd0, sens_valid},  8'h01);
    chk("pu_stable_e6", {6'd0, sens_stable}, 8'h03);
    chk("pu_no_change", n_change[7:0],       8'h00);

    // Move to OK (10)
    sens_raw = 2'b10;
    tick(6);
    chk("ok_stable", {6'd0, sens_stable}, 8'h02);
    chk("ok_change", {7'd0, change},      8'h01);
    tick(1);

    // Clean transition 10 -> 00: update exactly at k+5
    sens_raw = 2'b00;
    tick(5);
    chk("clean_k4_stable", {6'd0, sens_stable}, 8'h02);
    chk("clean_k4_change", {7'd0, change},      8'h00);
    tick(1);
    chk("clean_k5_stable", {6'd0, sens_stable}, 8'h00);
    chk("clean_k5_change", {7'd0, change},      8'h01);
    tick(1);
    chk("clean_k6_change", {7'd0, change},      8'h00);
    sens_raw = 2'b10;
    tick(7);
    chk("back_ok", {6'd0, sens_stable}, 8'h02);

    // Glitch: two samples of 00 then back to 10
    chk("glitch_before", {4'd0, glitch_cnt}, 8'h00);
    base_chg = n_change;
    sens_raw = 2'b00;
    tick(2);
    sens_raw = 2'b10;
    tick(6);
    chk("glitch_stable", {6'd0, sens_stable},        8'h02);
    chk("glitch_nochg",  8'(n_change - base_chg),    8'h00);
    chk("glitch_after",  {4'd0, glitch_cnt},         8'h01);

    // Inconsistent code 01, then recovery to 11
    sens_raw = 2'b01;
    tick(6);
    chk("inc_stable",   {6'd0, sens_stable}, 8'h01);
    chk("inc_change",   {7'd0, change},      8'h01);
    chk("inc_k5_flag",  {7'd0, inconsist},   8'h00);
    chk("inc_fault",    {4'd0, fault_cnt},   8'h01);
    tick(1);
    chk("inc_k6_flag",  {7'd0, inconsist},   8'h01);
    sens_raw = 2'b11;
    tick(6);
    chk("hot_stable",   {6'd0, sens_stable}, 8'h03);
    chk("hot_k5_flag",  {7'd0, inconsist},   8'h01);
    tick(1);
    chk("hot_k6_flag",  {7'd0, inconsist},   8'h00);
    chk("hot_fault",    {4'd0, fault_cnt},   8'h01);
    sens_raw = 2'b10;
    tick(7);
    chk("ok_again", {6'd0, sens_stable}, 8'h02);

    // Saturation: 20 aborted transitions on top of the earlier one
    base_chg = n_change;
    for (int i = 0; i < 20; i++) begin
      sens_raw = 2'b00;
      tick(1);
      sens_raw = 2'b10;
      tick(1);
    end
    tick(4);
    chk("sat_glitch", {4'd0, glitch_cnt},      8'h0F);
    chk("sat_stable", {6'd0, sens_stable},     8'h02);
    chk("sat_nochg",  8'(n_change - base_chg), 8'h00);

    // Toggling between two non-stable codes never qualifies a candidate
    base_chg = n_change;
    for (int i = 0; i < 12; i++) begin
      sens_raw = 2'b00;
      tick(1);
      sens_raw = 2'b11;
      tick(1);
    end
    chk("tog_stable", {6'd0, sens_stable},     8'h02);
    chk("tog_nochg",  8'(n_change - base_chg), 8'h00);
    sens_raw = 2'b10;
    tick(6);
    chk("tog_glitch_sat", {4'd0, glitch_cnt},  8'h0F);
    chk("tog_fault",      {4'd0, fault_cnt},   8'h01);

    // Async reset in the middle of SETTLE
    sens_raw = 2'b00;
    tick(3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_stable", {6'd0, sens_stable}, 8'h00);
    chk("arst_valid",  {7'd0, sens_valid},  8'h00);
    chk("arst_glitch", {4'd0, glitch_cnt},  8'h00);
    chk("arst_fault",  {4'd0, fault_cnt},   8'h00);
    chk("arst_change", {7'd0, change},      8'h00);
    sens_raw = 2'b11;
    #1;
    reset = 1'b0;
    base_chg = n_change;
    tick(5);
    chk("rinit_valid_e5", {7'd0, sens_valid}, 8'h00);
    tick(1);
    chk("rinit_valid_e6",  {7'd0, sens_valid},      8'h01);
    chk("rinit_stable_e6", {6'd0, sens_stable},     8'h03);
    chk("rinit_nochg",     8'(n_change - base_chg), 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
